board_ram_arbiter: RTL
======================

# board_ram_arbiter

Write-port arbiter for the 64-cell checkerboard state RAM. Shares the RAM's single write port (wr_en/wr_addr/wr_data) between N_REQ requesters: requester 0 is the board clear engine (mem_reset, a 64-write burst), and the others are game-logic writers such as stone placement and capture removal. It grants ownership with a request/grant handshake, locks the grant for a requester's whole burst, and registers the selected write onto the RAM port.

## Interface
- N_REQ, 3, number of requesters (2..8); index 0 is the high-priority clear requester.
- ADDR_W, 6, RAM address width (64 cells).
- DATA_W, 2, cell state width.
- MAX_HOLD, 64, maximum consecutive owned cycles for requesters 1..N_REQ-1 while others wait; valid range 1..127.

- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester ownership request; held high for the whole burst.
- we  in  N_REQ  per-requester write strobe.
- addr  in  N_REQ*ADDR_W  flattened addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- data  in  N_REQ*DATA_W  flattened write data, same packing as addr.
- gnt  out  N_REQ  registered one-hot grant; all zero means idle.
- ram_we  out  1  registered write enable to the RAM wr_en.
- ram_addr  out  ADDR_W  registered write address.
- ram_data  out  DATA_W  registered write data.
- busy  out  1  equals OR of gnt.
- drop  out  1  one-cycle pulse when a write is discarded because the requester does not own the port.

## Operation
- Ownership state: owner index plus valid flag (IDLE / OWN(i)); gnt is its one-hot decode.
- Arbitration happens at each posedge when either condition holds:
  - the state is IDLE, or
  - the current owner has req low, or
  - the hold timeout has fired.
- Arbitration rule:
  - If req[0] is high, requester 0 wins.
  - Otherwise, a round-robin search over 1..N_REQ-1 starts at rr_ptr. The winner w sets rr_ptr to w+1, wrapping to 1.
  - If no request is pending, the state goes to IDLE.
- There is no preemption. Requester 0 waits for the current owner to release or time out.
- The owner keeps the grant while its req stays high. Release and handover happen in the same edge, with no dead cycle.
- Hold timeout:
  - hold_cnt clears on every grant change and increments each cycle in OWN(i) for i≠0, saturating at MAX_HOLD.
  - When hold_cnt equals MAX_HOLD and any other req is high, ownership is forcibly passed on by the arbitration rule, excluding the current owner.
  - Requester 0 is never timed out.
- Write path:
  - When we[i] is high, gnt[i] is high and req[i] is high, the write is forwarded: ram_we=1 and ram_addr/ram_data come from slice i.
  - Any we[j] without gnt[j] is discarded and drop pulses. Several such strobes in one cycle produce a single pulse.
- Out-of-range indices cannot occur, because the grant is one-hot.

## Timing
- Reset values: gnt=0, busy=0, ram_we=0, ram_addr=0, ram_data=0, drop=0, rr_ptr=1, hold_cnt=0.
- Request to grant: req rising at edge k gives gnt at edge k+1 when the port is free.
- Write latency: a we sampled at edge k appears on ram_we/ram_addr/ram_data after edge k+1 and lands in the RAM at edge k+2. Throughput is one write per cycle.
- A requester may assert we in the first cycle gnt is visible.
- Release: req low sampled at edge k clears gnt (or moves it to the next winner) at edge k+1.
- Simultaneous release and new request: handled in one edge.
- Asynchronous reset mid-burst: all outputs clear immediately, and the partial burst is abandoned. The requester must restart its burst.

## Structure
- Shared package board_pkg holds:
  - BOARD_ADDR_W=6 and BOARD_DATA_W=2;
  - cell encoding constants CELL_EMPTY=2'b00, CELL_BLACK=2'b01, CELL_WHITE=2'b10;
  - requester index constants REQ_CLEAR=0, REQ_PLACE=1, REQ_CAPTURE=2.
- One sub-module, rr_picker: a combinational round-robin first-one finder taking a request mask and a start pointer and returning a valid flag and an index.

## Test plan
- Reset: hold rst_n=0 with req=3'b111 -> gnt=0, ram_we=0, drop=0. After release, gnt=3'b001 at the first edge.
- Single write: req[1]=1 alone, then we[1] with addr=6'd17, data=2'b10 -> gnt=3'b010 after 1 edge, ram_we pulses with addr 17 and data 10. A read of cell 17 afterwards returns 2'b10.
- Clear burst: mem_reset on requester 0 writes all 64 cells after random fill -> exactly 64 ram_we pulses and done asserts. All 64 reads return 2'b00.
- Lock and priority: requester 2 owns the port, then req[0] and req[1] rise -> gnt stays 3'b100 until req[2] drops, then becomes 3'b001 the next edge. After requester 0 releases, gnt moves to 3'b010.
- Round robin and timeout: req[1] and req[2] held high continuously with MAX_HOLD=4 -> ownership alternates between requesters 1 and 2. Each owns for 5 consecutive cycles (hold_cnt counts 0..4; handover on the edge where it equals 4).
- Unauthorized write: we[2] pulses while gnt=3'b010 -> single drop pulse, no ram_we, RAM contents unchanged.

Source files
------------

// File: rtl/board_pkg.sv
// Shared checkerboard constants: RAM geometry, cell encodings and arbiter requester indices.
package board_pkg;

    localparam int BOARD_ADDR_W = 6;
    localparam int BOARD_DATA_W = 2;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;

    localparam int REQ_CLEAR   = 0;
    localparam int REQ_PLACE   = 1;
    localparam int REQ_CAPTURE = 2;

    typedef enum logic {
        OWN_IDLE = 1'b0,
        OWN_BUSY = 1'b1
    } own_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin first-one finder: returns the first set mask bit at or after start,
// wrapping around, as an index in the mask's own numbering.
module rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] start,
    output logic             vld,
    output logic [IDX_W-1:0] idx
);

    logic [N-1:0]     rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;

    always_comb begin
        rot = N'({mask, mask} >> start);
        vld = |mask;
        off = '0;
        // Descending scan so the lowest rotated position wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = IDX_W'(k);
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= (IDX_W + 1)'(N)) sum = sum - (IDX_W + 1)'(N);
        idx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/board_ram_arbiter.sv
// Write-port arbiter for the 64-cell board RAM: request/grant ownership with burst lock,
// clear-engine priority, round-robin among game writers with a hold timeout, registered RAM write.
module board_ram_arbiter
    import board_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int ADDR_W   = BOARD_ADDR_W,
    parameter int DATA_W   = BOARD_DATA_W,
    parameter int MAX_HOLD = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          we,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    input  logic [N_REQ*DATA_W-1:0]   data,
    output logic [N_REQ-1:0]          gnt,
    output logic                      ram_we,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_data,
    output logic                      busy,
    output logic                      drop
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int PICK_N = N_REQ - 1;
    localparam int PICK_W = (PICK_N > 1) ? $clog2(PICK_N) : 1;
    localparam int HOLD_W = 7;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    own_state_e          state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_data_q, ram_data_d;
    logic                drop_q, drop_d;

    logic                owner_req, timeout, arbitrate, grant_change;
    logic [N_REQ-1:0]    cand;
    logic [PICK_W-1:0]   pick_start, pick_idx;
    logic                pick_vld;

    // A timed-out owner is removed from the candidate set so the port really moves on.
    assign owner_req  = |(req & gnt);
    assign timeout    = (state_q == OWN_BUSY) && (owner_q != IDX_W'(REQ_CLEAR)) &&
                        (hold_cnt_q == HOLD_MAX) && |(req & ~gnt);
    assign cand       = timeout ? (req & ~gnt) : req;
    assign pick_start = PICK_W'(rr_ptr_q - IDX_W'(1));

    rr_picker #(
        .N     (PICK_N),
        .IDX_W (PICK_W)
    ) u_rr_picker (
        .mask  (cand[N_REQ-1:1]),
        .start (pick_start),
        .vld   (pick_vld),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OWN_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= IDX_W'(1);
            hold_cnt_q <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        arbitrate = (state_q == OWN_IDLE) || !owner_req || timeout;
        if (arbitrate) begin
            if (cand[REQ_CLEAR]) begin
                state_d = OWN_BUSY;
                owner_d = IDX_W'(REQ_CLEAR);
            end else if (pick_vld) begin
                state_d  = OWN_BUSY;
                owner_d  = IDX_W'(pick_idx) + IDX_W'(1);
                rr_ptr_d = (owner_d == IDX_W'(N_REQ - 1)) ? IDX_W'(1) : owner_d + IDX_W'(1);
            end else begin
                state_d = OWN_IDLE;
            end
        end
        grant_change = (state_d != state_q) || (owner_d != owner_q);
        if (grant_change) begin
            hold_cnt_d = '0;
        end else if (state_q == OWN_BUSY && owner_q != IDX_W'(REQ_CLEAR) && hold_cnt_q != HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end else begin
            hold_cnt_d = hold_cnt_q;
        end
    end

    always_comb begin
        gnt = '0;
        if (state_q == OWN_BUSY) gnt[owner_q] = 1'b1;
        busy = |gnt;
    end

    // Address/data hold their last value between writes; only ram_we qualifies them.
    always_comb begin
        ram_we_d   = |(we & gnt & req);
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (we[i] && gnt[i] && req[i]) begin
                ram_addr_d = addr[i*ADDR_W +: ADDR_W];
                ram_data_d = data[i*DATA_W +: DATA_W];
            end
        end
        drop_d = |(we & ~gnt);
    end

    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_data = ram_data_q;
    assign drop     = drop_q;

endmodule
